fib_index: RTL and testbench



---
 rtl/fib_index.sv | 131 +++++++++++++
 tb/tb_fib_index.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fib_index.sv
// Inverse Fibonacci search: finds the smallest k with G(k) >= value, G = 1,2,3,5,8,...
// Optional macro FIB_INDEX_REM_EN adds rem_o = G(index) - value.
module fib_index #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [N-1:0] value_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] index_o,
    output logic         exact_o
`ifdef FIB_INDEX_REM_EN
    ,
    output logic [N:0]   rem_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N:0]     cur_q, cur_d;
    logic [N:0]     prv_q, prv_d;
    logic [N-1:0]   k_q, k_d;
    logic [N-1:0]   vreg_q, vreg_d;
    logic [N-1:0]   index_q, index_d;
    logic           exact_q, exact_d;
`ifdef FIB_INDEX_REM_EN
    logic [N:0]     rem_q, rem_d;
`endif

    logic [N:0]     vext;
    logic           reached;

    // cur/prv carry one extra bit so the term that first passes vreg never wraps
    assign vext    = {1'b0, vreg_q};
    assign reached = (cur_q >= vext);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= (N+1)'(1);
            prv_q   <= (N+1)'(1);
            k_q     <= '0;
            vreg_q  <= '0;
            index_q <= '0;
            exact_q <= 1'b0;
`ifdef FIB_INDEX_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            prv_q   <= prv_d;
            k_q     <= k_d;
            vreg_q  <= vreg_d;
            index_q <= index_d;
            exact_q <= exact_d;
`ifdef FIB_INDEX_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        prv_d   = prv_q;
        k_d     = k_q;
        vreg_d  = vreg_q;
        index_d = index_q;
        exact_d = exact_q;
`ifdef FIB_INDEX_REM_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    vreg_d  = value_i;
                    cur_d   = (N+1)'(1);
                    prv_d   = (N+1)'(1);
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reached) begin
                    index_d = k_q;
                    exact_d = (cur_q == vext);
`ifdef FIB_INDEX_REM_EN
                    rem_d   = cur_q - vext;
`endif
                    state_d = DONE;
                end else begin
                    prv_d = cur_q;
                    cur_d = cur_q + prv_q;
                    k_d   = k_q + N'(1);
                end
            end
            DONE: begin
                // Accepting here allows back-to-back searches without an IDLE gap
                if (start_i) begin
                    vreg_d  = value_i;
                    cur_d   = (N+1)'(1);
                    prv_d   = (N+1)'(1);
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign index_o = index_q;
    assign exact_o = exact_q;
`ifdef FIB_INDEX_REM_EN
    assign rem_o   = rem_q;
`endif

endmodule

// File: tb/tb_fib_index.sv
// Directed bench for fib_index with hand-computed indices, latencies and reset behaviour.
// Checks rem_o as well when FIB_INDEX_REM_EN is defined.
module tb_fib_index;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] value;
    logic         busy;
    logic         done;
    logic [N-1:0] index;
    logic         exact;
`ifdef FIB_INDEX_REM_EN
    logic [N:0]   rem;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int edges;

    fib_index #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .value_i (value),
        .busy_o  (busy),
        .done_o  (done),
        .index_o (index),
        .exact_o (exact)
`ifdef FIB_INDEX_REM_EN
        ,
        .rem_o   (rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Drive start for one accepting edge, then release it
    task automatic applyStimulus(input logic [N-1:0] v);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the accept edge until done is seen, bounded
    task automatic waitDone(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic checkResult(input string tag, input int expEdges, input int gotEdges,
                               input logic [N-1:0] expIndex, input logic expExact,
                               input logic [N:0] expRem);
        checkOutput({tag, "_latency"}, 32'(gotEdges), 32'(expEdges));
        checkOutput({tag, "_done"},  32'(done),  32'd1);
        checkOutput({tag, "_busy"},  32'(busy),  32'd0);
        checkOutput({tag, "_index"}, 32'(index), 32'(expIndex));
        checkOutput({tag, "_exact"}, 32'(exact), 32'(expExact));
`ifdef FIB_INDEX_REM_EN
        checkOutput({tag, "_rem"},   32'(rem),   32'(expRem));
`else
        if (expRem > 0) begin end
`endif
    endtask

    // One more edge with start low must drop done and return to idle
    task automatic checkIdleAfter(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_doneDrop"}, 32'(done), 32'd0);
        checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        #1;
        checkOutput("rst_busy",  32'(busy),  32'd0);
        checkOutput("rst_done",  32'(done),  32'd0);
        checkOutput("rst_index", 32'(index), 32'd0);
        checkOutput("rst_exact", 32'(exact), 32'd0);
`ifdef FIB_INDEX_REM_EN
        checkOutput("rst_rem",   32'(rem),   32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(8'd1);
        checkOutput("v1_busyRun", 32'(busy), 32'd1);
        waitDone(edges);
        checkResult("v1", 1, edges, 8'd0, 1'b1, 9'd0);
        checkIdleAfter("v1");

        applyStimulus(8'd4);
        checkOutput("v4_indexHeld", 32'(index), 32'd0);
        waitDone(edges);
        checkResult("v4", 4, edges, 8'd3, 1'b0, 9'd1);
        checkIdleAfter("v4");

        applyStimulus(8'd233);
        waitDone(edges);
        checkResult("v233", 12, edges, 8'd11, 1'b1, 9'd0);
        checkIdleAfter("v233");

        applyStimulus(8'd255);
        waitDone(edges);
        checkResult("v255", 13, edges, 8'd12, 1'b0, 9'd122);
        checkIdleAfter("v255");

        applyStimulus(8'd0);
        waitDone(edges);
        checkResult("v0", 1, edges, 8'd0, 1'b0, 9'd1);
        // Start again in the DONE cycle: accepted back-to-back
        start = 1'b1;
        value = 8'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_done", 32'(done), 32'd0);
        waitDone(edges);
        checkResult("v8", 5, edges, 8'd4, 1'b1, 9'd0);
        checkIdleAfter("v8");

        applyStimulus(8'd200);
        @(negedge clk);
        start = 1'b1;
        value = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 8'd77;
        checkOutput("ign_busy", 32'(busy), 32'd1);
        waitDone(edges);
        checkResult("v200", 12, edges + 1, 8'd11, 1'b0, 9'd33);
        checkIdleAfter("v200");

        applyStimulus(8'd144);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy",  32'(busy),  32'd0);
        checkOutput("arst_done",  32'(done),  32'd0);
        checkOutput("arst_index", 32'(index), 32'd0);
        checkOutput("arst_exact", 32'(exact), 32'd0);
`ifdef FIB_INDEX_REM_EN
        checkOutput("arst_rem",   32'(rem),   32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(8'd13);
        waitDone(edges);
        checkResult("v13", 6, edges, 8'd5, 1'b1, 9'd0);
        checkIdleAfter("v13");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
